// File: rtl/snow_pkg.sv
// Shared constants and types for the snowflake scene scheduler.
package snow_pkg;

  localparam int SPR_W  = 25;
  localparam int SPR_H  = 17;
  localparam int C_BASE = 64;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {
    IDLE   = 1'b0,
    UPDATE = 1'b1
  } state_t;

  // One flake: top-left row/column of its sprite box and its fall speed.
  // The speed is 1 or 2 lines per update step.
  typedef struct packed {
    logic [10:0] r;
    logic [10:0] c;
    logic [1:0]  speed;
  } flake_t;

endpackage

// File: rtl/snow_lfsr16.sv
// 16-bit Fibonacci LFSR used as the respawn-column random source.
module snow_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  output logic [15:0] q
);
  import snow_pkg::*;

  logic fb;

  // Feedback is the parity of the tapped bits.
  always_comb begin
    fb = ^(q & LFSR_TAPS);
  end

  // Shift left by one on each requested step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= SEED;
    end else if (step) begin
      q <= {q[14:0], fb};
    end
  end

endmodule

// File: rtl/snow_flake_sched.sv
// Multi-snowflake scheduler: per-frame position update during vblank and
// per-pixel lowest-index flake selection for the shared sprite lookup.
module snow_flake_sched #(
  parameter int          N_FLAKES = 4,
  parameter int          SPR_W    = snow_pkg::SPR_W,
  parameter int          SPR_H    = snow_pkg::SPR_H,
  parameter int          V_ACT    = 480,
  parameter int          C_BASE   = snow_pkg::C_BASE,
  parameter int          FALL_DIV = 2,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        enable,
  input  logic [10:0] col,
  input  logic [10:0] row,
  output logic [10:0] col_d,
  output logic [10:0] row_d,
  output logic [10:0] snow_c,
  output logic [10:0] snow_r,
  output logic        sel_valid,
  output logic [2:0]  sel_idx,
  output logic        busy
);
  import snow_pkg::*;

  localparam logic [15:0] FD_LAST  = 16'(FALL_DIV - 1);
  localparam logic [2:0]  LAST_IDX = 3'(N_FLAKES - 1);

  state_t      state, state_nx;
  logic [2:0]  idx, idx_nx;
  logic [15:0] frame_cnt, frame_cnt_nx;
  logic        lfsr_step;
  logic [15:0] lfsr_q;

  flake_t      fl [N_FLAKES];
  logic [10:0] dr [N_FLAKES];
  logic [10:0] dc [N_FLAKES];
  logic [N_FLAKES-1:0] hit;
  logic [2:0]  hit_idx;
  logic [10:0] hit_r, hit_c;

  snow_lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (lfsr_step),
    .q    (lfsr_q)
  );

  // FSM state, visit index and frame divider registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 3'd0;
      frame_cnt <= 16'd0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      frame_cnt <= frame_cnt_nx;
    end
  end

  // Next state: divide frame ticks, then walk every flake once per update.
  always_comb begin
    state_nx     = state;
    idx_nx       = idx;
    frame_cnt_nx = frame_cnt;
    busy         = 1'b0;
    lfsr_step    = 1'b0;
    case (state)
      IDLE: begin
        if (frame_tick && enable) begin
          if (frame_cnt >= FD_LAST) begin
            frame_cnt_nx = 16'd0;
            idx_nx       = 3'd0;
            state_nx     = UPDATE;
          end else begin
            frame_cnt_nx = frame_cnt + 16'd1;
          end
        end
      end
      UPDATE: begin
        busy      = 1'b1;
        lfsr_step = 1'b1;
        if (idx == LAST_IDX) begin
          idx_nx   = 3'd0;
          state_nx = IDLE;
        end else begin
          idx_nx = idx + 3'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Flake positions: advance the visited flake, respawning it at the top
  // with a random column and speed once it falls past the active area.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_FLAKES; i++) begin
        fl[i].r     <= 11'(i * (V_ACT / N_FLAKES));
        fl[i].c     <= 11'(C_BASE + i * 128);
        fl[i].speed <= 2'd1;
      end
    end else if (state == UPDATE) begin
      for (int i = 0; i < N_FLAKES; i++) begin
        if (idx == 3'(i)) begin
          if (({1'b0, fl[i].r} + {10'd0, fl[i].speed}) >= 12'(V_ACT)) begin
            fl[i].r     <= 11'd0;
            fl[i].c     <= 11'(C_BASE) + {2'b00, lfsr_q[8:0]};
            fl[i].speed <= {1'b0, lfsr_q[9]} + 2'd1;
          end else begin
            fl[i].r <= fl[i].r + {9'd0, fl[i].speed};
          end
        end
      end
    end
  end

  // Hit test per flake with wrapping differences, then lowest-index priority.
  always_comb begin
    hit     = '0;
    hit_idx = 3'd0;
    hit_r   = 11'd0;
    hit_c   = 11'd0;
    for (int i = 0; i < N_FLAKES; i++) begin
      dr[i]  = row - fl[i].r;
      dc[i]  = col - fl[i].c;
      hit[i] = (dr[i] < 11'(SPR_H)) && (dc[i] < 11'(SPR_W));
    end
    for (int i = N_FLAKES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_idx = 3'(i);
        hit_r   = fl[i].r;
        hit_c   = fl[i].c;
      end
    end
  end

  // Selection register stage; sprite coordinates hold when nothing is hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_d     <= 11'd0;
      row_d     <= 11'd0;
      snow_r    <= 11'd0;
      snow_c    <= 11'd0;
      sel_valid <= 1'b0;
      sel_idx   <= 3'd0;
    end else begin
      col_d     <= col;
      row_d     <= row;
      sel_valid <= |hit;
      sel_idx   <= hit_idx;
      if (|hit) begin
        snow_r <= hit_r;
        snow_c <= hit_c;
      end
    end
  end

endmodule
